// File: rtl/pulse_width_meter_us.sv
// Measures the high time of an asynchronous pulse in whole microseconds, reported in binary and BCD.
// Optional arm-to-rise timeout is built only when PWM_TIMEOUT_EN is defined.
module pulse_width_meter_us #(
   parameter int CLK_MHZ    = 125,
   parameter int TIMEOUT_US = 30000
) (
   input  logic        clk,
   input  logic        reset_p,
   input  logic        start,
   input  logic        sig_in,
   output logic        busy,
   output logic        done,
   output logic        valid,
   output logic        overflow,
   output logic        timeout,
   output logic [13:0] width_us,
   output logic [3:0]  bcd_1000,
   output logic [3:0]  bcd_100,
   output logic [3:0]  bcd_10,
   output logic [3:0]  bcd_1
);

   localparam int PW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;

   typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

   state_t state, next_state;

   logic          sync1, sync2, sync3;
   logic          rise, fall;
   logic [PW-1:0] presc;
   logic          tick;
   logic          at_max;
   logic          sat_hit;
   logic          to_expire;
   logic          accept;
   logic          enter_done;

   logic [3:0]  d1000, d100, d10, d1;
   logic [3:0]  d1000_nxt, d100_nxt, d10_nxt, d1_nxt;
   logic [13:0] bin, bin_nxt;

   // Two flops resynchronize the pin; the third holds the previous sample for edge detection.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= sig_in;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign rise = sync2 & ~sync3;
   assign fall = ~sync2 & sync3;

   // Microsecond prescaler only runs while waiting or measuring, and restarts on every state entry.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         presc <= '0;
      end else if (next_state != state) begin
         presc <= '0;
      end else if (state == ARM || state == MEASURE) begin
         presc <= tick ? '0 : presc + 1'b1;
      end else begin
         presc <= '0;
      end
   end

   assign tick       = (state == ARM || state == MEASURE) && (presc == PW'(CLK_MHZ - 1));
   assign at_max     = (d1000 == 4'd9) && (d100 == 4'd9) && (d10 == 4'd9) && (d1 == 4'd9);
   assign sat_hit    = (state == MEASURE) && tick && at_max;
   assign accept     = (state == IDLE) && start;
   assign enter_done = (state != DONE) && (next_state == DONE);

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A tick at 9999 ends the measurement immediately, even though the pin is still high.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = ARM;
         ARM: begin
            if (rise) next_state = MEASURE;
            else if (to_expire) next_state = DONE;
         end
         MEASURE: if (sat_hit || fall) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == ARM) || (state == MEASURE);
      done = (state == DONE);
   end

   // Next count includes a tick landing on the same cycle as the fall, so the load sees it.
   always_comb begin
      d1000_nxt = d1000;
      d100_nxt  = d100;
      d10_nxt   = d10;
      d1_nxt    = d1;
      bin_nxt   = bin;
      if (state == MEASURE && tick && !at_max) begin
         bin_nxt = bin + 14'd1;
         if (d1 == 4'd9) begin
            d1_nxt = 4'd0;
            if (d10 == 4'd9) begin
               d10_nxt = 4'd0;
               if (d100 == 4'd9) begin
                  d100_nxt  = 4'd0;
                  d1000_nxt = d1000 + 4'd1;
               end else begin
                  d100_nxt = d100 + 4'd1;
               end
            end else begin
               d10_nxt = d10 + 4'd1;
            end
         end else begin
            d1_nxt = d1 + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         d1000 <= 4'd0;
         d100  <= 4'd0;
         d10   <= 4'd0;
         d1    <= 4'd0;
         bin   <= 14'd0;
      end else if (accept) begin
         d1000 <= 4'd0;
         d100  <= 4'd0;
         d10   <= 4'd0;
         d1    <= 4'd0;
         bin   <= 14'd0;
      end else begin
         d1000 <= d1000_nxt;
         d100  <= d100_nxt;
         d10   <= d10_nxt;
         d1    <= d1_nxt;
         bin   <= bin_nxt;
      end
   end

   // Results are captured on the way into DONE so they are already visible while done is high.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         valid    <= 1'b0;
         overflow <= 1'b0;
         width_us <= 14'd0;
         bcd_1000 <= 4'd0;
         bcd_100  <= 4'd0;
         bcd_10   <= 4'd0;
         bcd_1    <= 4'd0;
      end else if (accept) begin
         valid    <= 1'b0;
         overflow <= 1'b0;
      end else if (enter_done) begin
         if (to_expire) begin
            valid    <= 1'b0;
            overflow <= 1'b0;
            width_us <= 14'd0;
            bcd_1000 <= 4'd0;
            bcd_100  <= 4'd0;
            bcd_10   <= 4'd0;
            bcd_1    <= 4'd0;
         end else begin
            valid    <= 1'b1;
            overflow <= sat_hit;
            width_us <= bin_nxt;
            bcd_1000 <= d1000_nxt;
            bcd_100  <= d100_nxt;
            bcd_10   <= d10_nxt;
            bcd_1    <= d1_nxt;
         end
      end
   end

`ifdef PWM_TIMEOUT_EN
   localparam int TW = (TIMEOUT_US > 1) ? $clog2(TIMEOUT_US) : 1;

   logic [TW-1:0] to_cnt;
   logic          timeout_r;

   assign to_expire = (state == ARM) && !rise && tick && (to_cnt == TW'(TIMEOUT_US - 1));
   assign timeout   = timeout_r;

   // Counts whole microseconds spent armed; the rising edge wins over an expiry in the same cycle.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         to_cnt    <= '0;
         timeout_r <= 1'b0;
      end else if (accept) begin
         to_cnt    <= '0;
         timeout_r <= 1'b0;
      end else begin
         if (state == ARM && tick) to_cnt <= to_cnt + 1'b1;
         if (to_expire) timeout_r <= 1'b1;
      end
   end
`else
   assign to_expire = 1'b0;
   assign timeout   = 1'b0;
`endif

endmodule
